pipe_hold_ctrl: RTL
===================

# pipe_hold_ctrl

Pipeline hold/flush scheduler for the five-stage core. Collects redirect and stall requests from EX, ID and the memory interface, and sequences the 2-bit hold flag consumed by the PC register and the IF/ID and ID/EX pipeline registers. Also forwards the jump redirect to the PC register. Multi-cycle events (branch flush, load-use bubble, divider wait, memory wait) are tracked by an internal state machine, so requesters only pulse or level-signal their condition.

## Interface
- AW, 64, instruction address width
- FLUSH_CYC, 2, cycles of flush after a taken jump (legal 1..3)
- HAZ_CYC, 1, bubble cycles per load-use hazard (legal 1..3)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- jump_en_i  in  1  EX: taken branch/jump this cycle
- jump_addr_i  in  AW  EX: redirect target
- load_hazard_i  in  1  ID: load-use hazard detected
- div_start_i  in  1  EX: multi-cycle divide issued this cycle
- div_done_i  in  1  divider: result ready (1-cycle pulse)
- mem_wait_i  in  1  memory interface not ready (level)
- hold_flag_o  out  2  to PC, IF/ID and ID/EX registers
- jump_en_o  out  1  to PC register: load jump_addr_o
- jump_addr_o  out  AW  to PC register: redirect target
- busy_o  out  1  state != RUN
- stall_cnt_o  out  32  cycles with hold_flag_o != 00, saturating

## Operation
- hold_flag_o encoding:
  - 00 run.
  - 01 bubble: PC and IF/ID hold; ID/EX loads NOP.
  - 10 freeze: PC, IF/ID and ID/EX all hold.
  - 11 flush: IF/ID loads NOP (address 0); ID/EX loads NOP.
- States are RUN, FLUSH, LDSTALL and DIVWAIT. There are two 2-bit down-counters, flush_cnt and haz_cnt, and a done_pend flag.
- RUN, priority mem_wait_i > jump_en_i > div_start_i > load_hazard_i:
  - mem_wait_i: hold 10, stay RUN. All other requests are ignored that cycle, and the requesters re-assert.
  - jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, hold 11. If FLUSH_CYC>1, go FLUSH with flush_cnt=FLUSH_CYC-2.
  - div_start_i: hold 10, go DIVWAIT.
  - load_hazard_i: hold 01. If HAZ_CYC>1, go LDSTALL with haz_cnt=HAZ_CYC-2.
  - None of the above: hold 00.
- FLUSH: hold 11 regardless of mem_wait_i. Decrement flush_cnt each cycle; when it is 0, return to RUN. jump_en_i, div_start_i and load_hazard_i are ignored, because squashed instructions cannot request.
- LDSTALL: hold 01; decrement haz_cnt; when it is 0, return to RUN. If mem_wait_i is high, hold is 10 and haz_cnt is frozen. jump_en_i is ignored, because EX holds a bubble.
- DIVWAIT: hold 10 while waiting.
  - div_done_i with mem_wait_i low: hold 00 that cycle, go RUN.
  - div_done_i with mem_wait_i high: set done_pend and keep hold 10.
  - With done_pend set, the first cycle with mem_wait_i low gives hold 00, clears done_pend and goes to RUN.
  - jump_en_i and load_hazard_i are ignored in DIVWAIT.
- jump_en_o and jump_addr_o: jump_en_o is high only in the RUN jump cycle. jump_addr_o is jump_addr_i when jump_en_o=1, else 0.
- stall_cnt_o: increments each cycle hold_flag_o != 00 and saturates at 32'hFFFF_FFFF.

## Timing
- hold_flag_o, jump_en_o and jump_addr_o are combinational (Mealy) from state and same-cycle inputs; the consuming registers act on the next rising edge.
- Flush length after a jump is exactly FLUSH_CYC cycles of 11, counting the jump cycle.
- Load-use bubble length is exactly HAZ_CYC cycles of 01, plus any mem_wait_i cycles.
- Divide stall lasts from the div_start_i cycle through the cycle before div_done_i (or before the release of done_pend).
- Reset values while rst=0: state RUN, counters 0, done_pend 0, hold_flag_o 00, jump_en_o 0, jump_addr_o 0, busy_o 0, stall_cnt_o 0. Outputs are forced low regardless of inputs.
- Reset asserted mid-sequence aborts immediately (asynchronously). The first cycle after release is RUN.

## Test plan
- Jump, FLUSH_CYC=2: jump_en_i=1, jump_addr_i=64'h8000_0040 at cycle N.
  - Cycle N: jump_en_o=1, addr 64'h8000_0040, hold 11.
  - Cycle N+1: hold 11, jump_en_o=0.
  - Cycle N+2: hold 00; stall_cnt_o +2.
- Load-use, HAZ_CYC=2: load_hazard_i pulse, with mem_wait_i high for the 2nd cycle.
  - Hold sequence is 01, 10, 01, 00.
  - busy_o is high for 2 cycles.
- Divide with memory wait: div_start_i at N, div_done_i at N+5, mem_wait_i high N+5..N+6.
  - hold 10 for N..N+6; hold 00 at N+7; state RUN.
- Simultaneous requests: jump_en_i, div_start_i and load_hazard_i all high in RUN.
  - Jump wins: hold 11 and jump_en_o=1.
  - No DIVWAIT or LDSTALL entry follows.
- Reset mid-DIVWAIT: rst low at N+2.
  - All outputs are 0 immediately; stall_cnt_o=0.
  - After release, an idle stimulus gives hold 00.
- Counter saturation: force stall_cnt_o near 32'hFFFF_FFFE, then stall 3 cycles.
  - stall_cnt_o reaches 32'hFFFF_FFFF and holds there.

Source files
------------

// File: rtl/pipe_hold_ctrl_if.sv
// Request/hold bundle between the pipeline requesters and the hold scheduler.
interface pipe_hold_ctrl_if #(
    parameter int unsigned AW = 64
);
    logic          jump_en_i;
    logic [AW-1:0] jump_addr_i;
    logic          load_hazard_i;
    logic          div_start_i;
    logic          div_done_i;
    logic          mem_wait_i;
    logic [1:0]    hold_flag_o;
    logic          jump_en_o;
    logic [AW-1:0] jump_addr_o;
    logic          busy_o;
    logic [31:0]   stall_cnt_o;

    // Requester side: drives requests, consumes hold/redirect.
    modport master (
        output jump_en_i, jump_addr_i, load_hazard_i, div_start_i, div_done_i, mem_wait_i,
        input  hold_flag_o, jump_en_o, jump_addr_o, busy_o, stall_cnt_o
    );

    // Scheduler side.
    modport slave (
        input  jump_en_i, jump_addr_i, load_hazard_i, div_start_i, div_done_i, mem_wait_i,
        output hold_flag_o, jump_en_o, jump_addr_o, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush scheduler: sequences the 2-bit hold flag for PC, IF/ID
// and ID/EX, forwards the jump redirect, and counts stalled cycles.
module pipe_hold_ctrl #(
    parameter int unsigned AW        = 64,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned HAZ_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hold_ctrl_if.slave  bus
);
    localparam int unsigned CW = 32;

    localparam logic [1:0] HOLD_RUN    = 2'b00;
    localparam logic [1:0] HOLD_BUBBLE = 2'b01;
    localparam logic [1:0] HOLD_FREEZE = 2'b10;
    localparam logic [1:0] HOLD_FLUSH  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_LDSTALL = 2'd2,
        ST_DIVWAIT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic [1:0]    haz_cnt_q, haz_cnt_d;
    logic          done_pend_q, done_pend_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0]    hold_c;
    logic          jump_en_c;
    logic [AW-1:0] jump_addr_c;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 2'd0;
            haz_cnt_q   <= 2'd0;
            done_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            haz_cnt_q   <= haz_cnt_d;
            done_pend_q <= done_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and Mealy hold/redirect outputs.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        haz_cnt_d   = haz_cnt_q;
        done_pend_d = done_pend_q;
        hold_c      = HOLD_RUN;
        jump_en_c   = 1'b0;
        jump_addr_c = '0;

        unique case (state_q)
            ST_RUN: begin
                if (bus.mem_wait_i) begin
                    hold_c = HOLD_FREEZE;
                end else if (bus.jump_en_i) begin
                    jump_en_c   = 1'b1;
                    jump_addr_c = bus.jump_addr_i;
                    hold_c      = HOLD_FLUSH;
                    if (FLUSH_CYC > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = 2'(FLUSH_CYC - 2);
                    end
                end else if (bus.div_start_i) begin
                    hold_c  = HOLD_FREEZE;
                    state_d = ST_DIVWAIT;
                end else if (bus.load_hazard_i) begin
                    hold_c = HOLD_BUBBLE;
                    if (HAZ_CYC > 1) begin
                        state_d   = ST_LDSTALL;
                        haz_cnt_d = 2'(HAZ_CYC - 2);
                    end
                end
            end
            ST_FLUSH: begin
                // Flush cannot be stretched by memory wait: the NOPs are already in flight.
                hold_c = HOLD_FLUSH;
                if (flush_cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            ST_LDSTALL: begin
                if (bus.mem_wait_i) begin
                    hold_c = HOLD_FREEZE;
                end else begin
                    hold_c = HOLD_BUBBLE;
                    if (haz_cnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        haz_cnt_d = haz_cnt_q - 2'd1;
                    end
                end
            end
            ST_DIVWAIT: begin
                hold_c = HOLD_FREEZE;
                if (done_pend_q) begin
                    if (!bus.mem_wait_i) begin
                        hold_c      = HOLD_RUN;
                        done_pend_d = 1'b0;
                        state_d     = ST_RUN;
                    end
                end else if (bus.div_done_i) begin
                    if (bus.mem_wait_i) begin
                        done_pend_d = 1'b1;
                    end else begin
                        hold_c  = HOLD_RUN;
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating count of cycles with a non-run hold flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((hold_c != HOLD_RUN) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    // Combinational outputs are held low while reset is asserted.
    assign bus.hold_flag_o = rst ? hold_c      : HOLD_RUN;
    assign bus.jump_en_o   = rst ? jump_en_c   : 1'b0;
    assign bus.jump_addr_o = rst ? jump_addr_c : '0;
    assign bus.busy_o      = (state_q != ST_RUN);
    assign bus.stall_cnt_o = stall_cnt_q;
endmodule
